// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// The optional stall watchdog is enabled with the WB_ARB_TIMEOUT_EN macro.
package wb_arb_pkg;

  // Arbiter grant state: no owner, master 0 owns the bus, master 1 owns the bus.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // Default watchdog limit in cycles.
  localparam int TIMEOUT_CYCLES_DEF = 255;

  // Counter width able to hold the value 'cycles' itself, since the counter
  // has to reach the limit before it fires.
  function automatic int cnt_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

  // Counter width for the default limit.
  localparam int TO_CNT_W = cnt_width(TIMEOUT_CYCLES_DEF);

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog for the granted Wishbone strobe. It counts cycles in which
// the owner strobes and the slave gives neither ack nor err. When the count
// reaches TIMEOUT_CYCLES it raises 'expire' for one cycle and restarts.
// The top instantiates this only when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_timeout
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic granted,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  // Fire only while the owner is still strobing. This stops a stale count
  // from firing during IDLE.
  assign expire = granted & stb & (cnt_q == LIMIT);

  // Count stalled strobe cycles. Clear on a slave response, when not
  // granted, or in the cycle the watchdog fires.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (!granted || ack || err || expire) begin
      cnt_q <= '0;
    end else if (stb) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter with a fair tie-break.
// - A master is granted on the edge after it raises cyc.
// - It keeps the grant for as long as it holds cyc. There is no preemption.
// - An IDLE cycle always separates two grants.
// - On a tie, the master that was not granted last wins.
// - The slave-side bus is a combinational mux of the owner's signals.
// - Responses are returned only to the owner.
// Optional: define WB_ARB_TIMEOUT_EN to add a watchdog. It returns err to an
// owner whose strobe has not been answered within TIMEOUT_CYCLES cycles.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int AW             = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  // master 0
  input  logic [AW-1:0] m0_adr_i,
  input  logic [31:0]   m0_dat_i,
  input  logic [3:0]    m0_sel_i,
  input  logic          m0_we_i,
  input  logic          m0_cyc_i,
  input  logic          m0_stb_i,
  output logic [31:0]   m0_dat_o,
  output logic          m0_ack_o,
  output logic          m0_err_o,
  // master 1
  input  logic [AW-1:0] m1_adr_i,
  input  logic [31:0]   m1_dat_i,
  input  logic [3:0]    m1_sel_i,
  input  logic          m1_we_i,
  input  logic          m1_cyc_i,
  input  logic          m1_stb_i,
  output logic [31:0]   m1_dat_o,
  output logic          m1_ack_o,
  output logic          m1_err_o,
  // shared slave side
  output logic [AW-1:0] s_adr_o,
  output logic [31:0]   s_dat_o,
  output logic [3:0]    s_sel_o,
  output logic          s_we_o,
  output logic          s_cyc_o,
  output logic          s_stb_o,
  input  logic [31:0]   s_dat_i,
  input  logic          s_ack_i,
  input  logic          s_err_i,
  // one-hot grant, also serves as the observable FSM state
  output logic [1:0]    owner_o
);

  // Handshake: a beat completes in a cycle where s_cyc_o & s_stb_o & (s_ack_i | s_err_i).
  // An ack or err that arrives while no master is granted goes to nobody and is dropped.

  arb_state_t state_q, state_d;
  logic       last_q, last_d;   // 0: master 0 was granted last, 1: master 1
  logic       to_expire;

`ifdef WB_ARB_TIMEOUT_EN
  logic granted;
  logic cur_stb;

  assign granted = (state_q != IDLE);
  assign cur_stb = (state_q == GNT0) ? m0_stb_i :
                   (state_q == GNT1) ? m1_stb_i : 1'b0;

  wb_arb_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .reset_n (reset_n),
    .granted (granted),
    .stb     (cur_stb),
    .ack     (s_ack_i),
    .err     (s_err_i),
    .expire  (to_expire)
  );
`else
  // Without the watchdog a hung slave simply keeps the grant.
  assign to_expire = 1'b0;
`endif

  // State and last-grant registers. Reset makes master 0 win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next-state logic. Grant from IDLE only, and hold the grant until the
  // owner drops cyc.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          if (last_q) begin
            state_d = GNT0;
            last_d  = 1'b0;
          end else begin
            state_d = GNT1;
            last_d  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          state_d = GNT0;
          last_d  = 1'b0;
        end else if (m1_cyc_i) begin
          state_d = GNT1;
          last_d  = 1'b1;
        end
      end
      GNT0: if (!m0_cyc_i) state_d = IDLE;
      GNT1: if (!m1_cyc_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output mux. Route the owner's request to the slave and the slave's
  // response back to the owner. Drive everything to zero in IDLE.
  always_comb begin
    owner_o  = 2'b00;
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    unique case (state_q)
      GNT0: begin
        owner_o  = 2'b01;
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~to_expire;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | to_expire;
      end
      GNT1: begin
        owner_o  = 2'b10;
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~to_expire;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | to_expire;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Testbench for wb_arbiter2: directed scenarios followed by a randomized soak.
// Each cycle's outputs are compared with a behavioural arbitration model.
// Define WB_ARB_TIMEOUT_EN to build the bench together with the watchdog.
module tb_wb_arbiter2;

`ifdef WB_ARB_TIMEOUT_EN
  localparam int TB_T  = 8;
  localparam bit TO_EN = 1'b1;
`else
  localparam int TB_T  = 255;
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  // ---------------- DUT signals ----------------
  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [31:0] s_dat_i;
  logic        s_ack_i, s_err_i;

  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [1:0]  owner_o;

  wb_arbiter2 #(.TIMEOUT_CYCLES(TB_T), .AW(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .owner_o(owner_o)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Reference model: current owner (-1 = none), the master granted last,
  // and the number of stalled strobe cycles since the last clear.
  int model_owner;
  int model_last;
  int stall;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    model_owner = -1;
    model_last  = 1;
    stall       = 0;
  endtask

  function automatic bit model_expire();
    if (!TO_EN || model_owner < 0) return 1'b0;
    return m_stb[model_owner] && (stall == TB_T);
  endfunction

  // Compare every DUT output against what the model predicts for this cycle.
  task automatic compare_outputs();
    int o;
    bit ex;
    logic [1:0] exp_owner;
    o  = model_owner;
    ex = model_expire();
    exp_owner = (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10);
    check("owner", owner_o, exp_owner);
    check("s_cyc", s_cyc_o, (o < 0) ? 1'b0 : m_cyc[o]);
    check("s_stb", s_stb_o, (o < 0) ? 1'b0 : (m_stb[o] && !ex));
    check("s_adr", s_adr_o, (o < 0) ? 32'h0 : m_adr[o]);
    check("s_dat", s_dat_o, (o < 0) ? 32'h0 : m_dat[o]);
    check("s_sel", s_sel_o, (o < 0) ? 4'h0 : m_sel[o]);
    check("s_we",  s_we_o,  (o < 0) ? 1'b0 : m_we[o]);
    check("m0_ack", m0_ack_o, (o == 0) && s_ack_i);
    check("m1_ack", m1_ack_o, (o == 1) && s_ack_i);
    check("m0_err", m0_err_o, (o == 0) && (s_err_i || ex));
    check("m1_err", m1_err_o, (o == 1) && (s_err_i || ex));
    check("m0_dat", m0_dat_o, (o == 0) ? s_dat_i : 32'h0);
    check("m1_dat", m1_dat_o, (o == 1) ? s_dat_i : 32'h0);
  endtask

  // Advance the model at a rising edge, using the inputs sampled at that edge.
  task automatic model_update();
    bit ex;
    if (!reset_n) begin
      model_reset();
      return;
    end
    ex = model_expire();
    if (model_owner < 0 || s_ack_i || s_err_i || ex) stall = 0;
    else if (m_stb[model_owner]) stall++;
    if (model_owner < 0) begin
      if (m_cyc[0] && m_cyc[1]) model_owner = (model_last == 1) ? 0 : 1;
      else if (m_cyc[0])        model_owner = 0;
      else if (m_cyc[1])        model_owner = 1;
      if (model_owner >= 0) model_last = model_owner;
    end else if (!m_cyc[model_owner]) begin
      model_owner = -1;
    end
  endtask

  // Driver step. The caller drives inputs at the falling edge. This task
  // checks the outputs, crosses one rising edge, and returns at the next
  // falling edge.
  task automatic step();
    #1;
    compare_outputs();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      m_cyc[i] = 1'b0; m_stb[i] = 1'b0; m_we[i] = 1'b0;
      m_adr[i] = '0;   m_dat[i] = '0;   m_sel[i] = '0;
    end
    s_ack_i = 1'b0; s_err_i = 1'b0; s_dat_i = '0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    model_reset();
    step();
    reset_n = 1'b1;
  endtask

  int err_cnt, err_cyc, rise_cyc;
  logic [31:0] sb_val;

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset: outputs stay zero while held in reset, even with requests and a slave ack present.
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1; m_stb[0] = 1'b1; m_stb[1] = 1'b1;
    s_ack_i = 1'b1; s_err_i = 1'b1;
    step();
    #1;
    check("rst_owner", owner_o, 2'b00);
    check("rst_scyc", s_cyc_o, 1'b0);
    check("rst_m0ack", m0_ack_o, 1'b0);
    check("rst_m1err", m1_err_o, 1'b0);
    step();
    idle_inputs();
    reset_n = 1'b1;
    step();

    // Single read by m0; the slave acks two cycles after the grant.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_adr[0] = 32'h0000_1000; m_we[0] = 1'b0;
    step();
    #1;
    check("rd_scyc", s_cyc_o, 1'b1);
    check("rd_owner", owner_o, 2'b01);
    check("rd_sadr", s_adr_o, 32'h0000_1000);
    step();
    step();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    check("rd_m0ack", m0_ack_o, 1'b1);
    check("rd_m1ack", m1_ack_o, 1'b0);
    if (m0_ack_o) begin
      sb_val = exp_q.pop_front();
      check("rd_m0dat", m0_dat_o, sb_val);
    end
    step();
    idle_inputs();
    step();
    step();

    // Tie after reset goes to m0; handover to m1 takes one IDLE cycle; the next tie goes back to m0.
    do_reset();
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    step();
    check("tie1_owner", owner_o, 2'b01);
    m_cyc[0] = 1'b0;
    step();
    check("hand_idle", owner_o, 2'b00);
    step();
    check("hand_m1", owner_o, 2'b10);
    m_cyc[1] = 1'b0;
    step();
    step();
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    step();
    check("tie2_owner", owner_o, 2'b01);
    idle_inputs();
    step();
    step();

    // m1 does three write beats with sel 0011 while m0 waits.
    m_cyc[1] = 1'b1; m_we[1] = 1'b1; m_sel[1] = 4'b0011;
    step();
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      m_adr[1] = $urandom; m_dat[1] = $urandom; m_stb[1] = 1'b1; s_ack_i = 1'b1;
      exp_q.push_back(m_dat[1]);
      #1;
      check("wr_owner", owner_o, 2'b10);
      check("wr_sel", s_sel_o, 4'b0011);
      check("wr_sb_ready", (s_stb_o && s_ack_i), 1'b1);
      if (s_stb_o && s_ack_i && exp_q.size() != 0) begin
        sb_val = exp_q.pop_front();
        check("wr_sdat", s_dat_o, sb_val);
      end
      step();
    end
    m_stb[1] = 1'b0; s_ack_i = 1'b0; m_cyc[1] = 1'b0;
    step();
    check("wr_gap", owner_o, 2'b00);
    step();
    check("wr_m0_after", owner_o, 2'b01);
    check("sb_empty", exp_q.size(), 0);
    idle_inputs();
    step();
    step();

    // Asynchronous reset in the middle of an m1 transfer.
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    step();
    s_ack_i = 1'b1;
    #1;
    check("pre_rst_ack", m1_ack_o, 1'b1);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("arst_scyc", s_cyc_o, 1'b0);
    check("arst_owner", owner_o, 2'b00);
    check("arst_m1ack", m1_ack_o, 1'b0);
    step();
    reset_n = 1'b1;
    s_ack_i = 1'b0;
    m_cyc[0] = 1'b1; m_cyc[1] = 1'b1;
    step();
    check("arst_tie", owner_o, 2'b01);
    idle_inputs();
    step();
    step();

    // Hung slave: count err pulses seen by m0 over a fixed window.
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    err_cnt = 0; err_cyc = -1; rise_cyc = -1;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      #1;
      if (s_stb_o && rise_cyc < 0) rise_cyc = i;
      if (m0_err_o) begin err_cnt++; err_cyc = i; end
      step();
    end
    check("to_err_once", err_cnt, 1);
    check("to_err_delay", err_cyc - rise_cyc, TB_T);
`else
    for (int i = 0; i < 100; i++) begin
      #1;
      if (m0_err_o) err_cnt++;
      step();
    end
    check("no_to_err", err_cnt, 0);
    check("hung_owner", owner_o, 2'b01);
`endif
    idle_inputs();
    step();
    step();

    // Randomized soak against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 7) == 0) m_cyc[i] = ~m_cyc[i];
        m_stb[i] = 1'($urandom_range(0, 1));
        m_adr[i] = $urandom;
        m_dat[i] = $urandom;
        m_sel[i] = 4'($urandom_range(0, 15));
        m_we[i]  = 1'($urandom_range(0, 1));
      end
      s_ack_i = 1'($urandom_range(0, 1));
      s_err_i = ($urandom_range(0, 15) == 0);
      s_dat_i = $urandom;
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
